// File: rtl/dispatcher_pkg.sv
// Shared types and default sizing for the dual-issue dispatcher.
// The optional timeout (DISPATCH_TIMEOUT_EN) relies on DEF_TIMEOUT_CYCLES.
package dispatcher_pkg;

  localparam int DEF_REGISTER_AMOUNT = 32;
  localparam int DEF_REG_CTN_WIDTH   = $clog2(DEF_REGISTER_AMOUNT);
  localparam int DEF_TIMEOUT_CYCLES  = 16;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_BUSY_1 = 2'd1,
    WAIT_BUSY_2 = 2'd2,
    SYNC_WAIT   = 2'd3
  } dispatch_state_t;

endpackage

// File: rtl/register_hazard_checker.sv
// Combinational hazard check: flags any used, non-zero register index that the
// register manager has marked as in flight.
module register_hazard_checker
  import dispatcher_pkg::*;
#(
  parameter int REGISTER_AMOUNT = DEF_REGISTER_AMOUNT,
  parameter int REG_CTN_WIDTH   = $clog2(REGISTER_AMOUNT)
) (
  input  logic [REG_CTN_WIDTH*3-1:0] i_rd,
  input  logic [REG_CTN_WIDTH*2-1:0] i_rs,
  input  logic                       i_multi,
  input  logic [REGISTER_AMOUNT-1:0] i_table,
  output logic                       o_hazard
);

  logic [REG_CTN_WIDTH-1:0] w_idx [5];
  logic [4:0]               w_used;

  // Second and third destinations only matter for three-destination ops.
  always_comb begin
    w_idx[0] = i_rd[REG_CTN_WIDTH-1:0];
    w_idx[1] = i_rd[2*REG_CTN_WIDTH-1:REG_CTN_WIDTH];
    w_idx[2] = i_rd[3*REG_CTN_WIDTH-1:2*REG_CTN_WIDTH];
    w_idx[3] = i_rs[REG_CTN_WIDTH-1:0];
    w_idx[4] = i_rs[2*REG_CTN_WIDTH-1:REG_CTN_WIDTH];
    w_used   = {1'b1, 1'b1, i_multi, i_multi, 1'b1};
    o_hazard = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (w_used[i] && (w_idx[i] != '0) && i_table[w_idx[i]]) begin
        o_hazard = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dual_issue_dispatcher.sv
// Dispatches instructions to one of two processors, holding on hazards and barriers.
// Define DISPATCH_TIMEOUT_EN to bound the waits and enable the sticky dispatch_error.
module dual_issue_dispatcher
  import dispatcher_pkg::*;
#(
  parameter int REGISTER_AMOUNT = DEF_REGISTER_AMOUNT,
  parameter int REG_CTN_WIDTH   = $clog2(REGISTER_AMOUNT),
  parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       instr_valid,
  output logic                       instr_ready,
  input  logic                       instr_sync,
  input  logic                       instr_multi,
  input  logic [REG_CTN_WIDTH*3-1:0] instr_rd,
  input  logic [REG_CTN_WIDTH*2-1:0] instr_rs,
  input  logic [REGISTER_AMOUNT-1:0] processing_register_table,
  input  logic                       processor_idle_1,
  input  logic                       processor_idle_2,
  input  logic                       synchronized_processors,
  output logic                       boot_renew_register_1,
  output logic                       boot_renew_register_2,
  output logic                       boot_renew_3registers_2,
  output logic [REG_CTN_WIDTH*3-1:0] register_num,
  output logic                       dispatch_error
);

  dispatch_state_t            r_state;
  logic                       r_boot_1;
  logic                       r_boot_2;
  logic                       r_boot_3_2;
  logic [REG_CTN_WIDTH*3-1:0] r_register_num;
  logic                       w_hazard;
  logic                       w_target_1;
  logic                       w_target_2;
  logic                       w_accept;
  logic                       w_sync_release;
  logic                       w_timeout;

  register_hazard_checker #(
    .REGISTER_AMOUNT(REGISTER_AMOUNT),
    .REG_CTN_WIDTH  (REG_CTN_WIDTH)
  ) u_hazard (
    .i_rd    (instr_rd),
    .i_rs    (instr_rs),
    .i_multi (instr_multi),
    .i_table (processing_register_table),
    .o_hazard(w_hazard)
  );

  // Multi ops may only go to processor 2; otherwise processor 1 has priority.
  always_comb begin
    w_target_1     = !instr_multi && processor_idle_1;
    w_target_2     = processor_idle_2 && (instr_multi || !processor_idle_1);
    w_accept       = (r_state == IDLE) && instr_valid && !instr_sync && !w_hazard
                     && (w_target_1 || w_target_2);
    w_sync_release = (r_state == SYNC_WAIT) && processor_idle_1 && processor_idle_2
                     && synchronized_processors;
    instr_ready    = !rst && (w_accept || w_sync_release);
  end

`ifdef DISPATCH_TIMEOUT_EN
  localparam int TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TIMER_W-1:0] r_timer;
  logic               r_dispatch_error;
  logic               w_wait_exit;

  always_comb begin
    w_wait_exit = ((r_state == WAIT_BUSY_1) && !processor_idle_1)
                  || ((r_state == WAIT_BUSY_2) && !processor_idle_2)
                  || w_sync_release;
    w_timeout   = (r_state != IDLE) && !w_wait_exit
                  && (r_timer == TIMER_W'(TIMEOUT_CYCLES - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_timer          <= '0;
      r_dispatch_error <= 1'b0;
    end else begin
      if ((r_state == IDLE) || w_wait_exit || w_timeout) r_timer <= '0;
      else r_timer <= r_timer + 1'b1;
      if (w_timeout) r_dispatch_error <= 1'b1;
    end
  end

  assign dispatch_error = r_dispatch_error;
`else
  assign w_timeout      = 1'b0;
  assign dispatch_error = 1'b0;
`endif

  // Boot pulses default low each cycle, so an acceptance yields exactly one pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_boot_1       <= 1'b0;
      r_boot_2       <= 1'b0;
      r_boot_3_2     <= 1'b0;
      r_register_num <= '0;
    end else begin
      r_boot_1   <= 1'b0;
      r_boot_2   <= 1'b0;
      r_boot_3_2 <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_register_num <= instr_rd;
            if (w_target_1) begin
              r_boot_1 <= 1'b1;
              r_state  <= WAIT_BUSY_1;
            end else begin
              if (instr_multi) r_boot_3_2 <= 1'b1;
              else r_boot_2 <= 1'b1;
              r_state <= WAIT_BUSY_2;
            end
          end else if (instr_valid && instr_sync) begin
            r_state <= SYNC_WAIT;
          end
        end
        WAIT_BUSY_1: if (!processor_idle_1 || w_timeout) r_state <= IDLE;
        WAIT_BUSY_2: if (!processor_idle_2 || w_timeout) r_state <= IDLE;
        SYNC_WAIT:   if (w_sync_release || w_timeout) r_state <= IDLE;
        default:     r_state <= IDLE;
      endcase
    end
  end

  assign boot_renew_register_1   = r_boot_1;
  assign boot_renew_register_2   = r_boot_2;
  assign boot_renew_3registers_2 = r_boot_3_2;
  assign register_num            = r_register_num;

endmodule

// File: tb/tb_dual_issue_dispatcher.sv
// Self-checking bench for dual_issue_dispatcher: directed scenarios then random traffic
// against a behavioural model; the timeout expectations follow DISPATCH_TIMEOUT_EN.
module tb_dual_issue_dispatcher;

  localparam int REGS    = 32;
  localparam int W       = 5;
  localparam int TIMEOUT = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            instr_valid;
  logic            instr_ready;
  logic            instr_sync;
  logic            instr_multi;
  logic [3*W-1:0]  instr_rd;
  logic [2*W-1:0]  instr_rs;
  logic [REGS-1:0] processing_register_table;
  logic            processor_idle_1;
  logic            processor_idle_2;
  logic            synchronized_processors;
  logic            boot_renew_register_1;
  logic            boot_renew_register_2;
  logic            boot_renew_3registers_2;
  logic [3*W-1:0]  register_num;
  logic            dispatch_error;

  int checks = 0;
  int errors = 0;

  // Behavioural model: what the dispatcher is currently waiting for
  // (0 nothing, 1 processor 1 busy, 2 processor 2 busy, 3 barrier release).
  int             mWaitFor  = 0;
  int             mWaitLen  = 0;
  logic [3*W-1:0] mRegNum   = '0;
  bit             mError    = 1'b0;
  bit             mBoot1    = 1'b0;
  bit             mBoot2    = 1'b0;
  bit             mBoot3    = 1'b0;

  dual_issue_dispatcher #(
    .REGISTER_AMOUNT(REGS),
    .REG_CTN_WIDTH  (W),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk                      (clk),
    .rst                      (rst),
    .instr_valid              (instr_valid),
    .instr_ready              (instr_ready),
    .instr_sync               (instr_sync),
    .instr_multi              (instr_multi),
    .instr_rd                 (instr_rd),
    .instr_rs                 (instr_rs),
    .processing_register_table(processing_register_table),
    .processor_idle_1         (processor_idle_1),
    .processor_idle_2         (processor_idle_2),
    .synchronized_processors  (synchronized_processors),
    .boot_renew_register_1    (boot_renew_register_1),
    .boot_renew_register_2    (boot_renew_register_2),
    .boot_renew_3registers_2  (boot_renew_3registers_2),
    .register_num             (register_num),
    .dispatch_error           (dispatch_error)
  );

  always #5 clk = ~clk;

  function automatic bit hasHazard(bit m, logic [3*W-1:0] rd, logic [2*W-1:0] rs,
                                   logic [REGS-1:0] tbl);
    int idx[$];
    idx.push_back(int'(rd[4:0]));
    idx.push_back(int'(rs[4:0]));
    idx.push_back(int'(rs[9:5]));
    if (m) begin
      idx.push_back(int'(rd[9:5]));
      idx.push_back(int'(rd[14:10]));
    end
    foreach (idx[k]) if (idx[k] != 0 && tbl[idx[k]]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int pickTarget(bit m, bit i1, bit i2);
    if (m) return i2 ? 2 : 0;
    if (i1) return 1;
    if (i2) return 2;
    return 0;
  endfunction

  task automatic checkOutput(input string tag, input logic [3*W-1:0] observed,
                             input logic [3*W-1:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // One clock cycle: drive inputs, check ready before the edge, advance the
  // model across the edge, then check the registered outputs.
  task automatic applyStimulus(input bit r, input bit v, input bit s, input bit m,
                               input logic [3*W-1:0] rd, input logic [2*W-1:0] rs,
                               input logic [REGS-1:0] tbl, input bit i1, input bit i2,
                               input bit sy);
    bit expReady;
    int tgt;
    @(negedge clk);
    rst = r; instr_valid = v; instr_sync = s; instr_multi = m;
    instr_rd = rd; instr_rs = rs; processing_register_table = tbl;
    processor_idle_1 = i1; processor_idle_2 = i2; synchronized_processors = sy;
    #1;
    tgt = pickTarget(m, i1, i2);
    if (r) expReady = 1'b0;
    else if (mWaitFor == 0) expReady = v && !s && !hasHazard(m, rd, rs, tbl) && (tgt != 0);
    else if (mWaitFor == 3) expReady = i1 && i2 && sy;
    else expReady = 1'b0;
    checkOutput("instr_ready", {14'd0, instr_ready}, {14'd0, expReady});
    @(posedge clk);
    mBoot1 = 1'b0; mBoot2 = 1'b0; mBoot3 = 1'b0;
    if (r) begin
      mWaitFor = 0; mWaitLen = 0; mRegNum = '0; mError = 1'b0;
    end else if (mWaitFor == 0) begin
      mWaitLen = 0;
      if (expReady) begin
        mRegNum = rd;
        mWaitFor = tgt;
        if (tgt == 1) mBoot1 = 1'b1;
        else if (m) mBoot3 = 1'b1;
        else mBoot2 = 1'b1;
      end else if (v && s) begin
        mWaitFor = 3;
      end
    end else if ((mWaitFor == 1 && !i1) || (mWaitFor == 2 && !i2) || (mWaitFor == 3 && expReady)) begin
      mWaitFor = 0;
    end else begin
      mWaitLen++;
`ifdef DISPATCH_TIMEOUT_EN
      if (mWaitLen == TIMEOUT) begin
        mError = 1'b1;
        mWaitFor = 0;
      end
`endif
    end
    #1;
    checkOutput("boot_renew_register_1", {14'd0, boot_renew_register_1}, {14'd0, mBoot1});
    checkOutput("boot_renew_register_2", {14'd0, boot_renew_register_2}, {14'd0, mBoot2});
    checkOutput("boot_renew_3registers_2", {14'd0, boot_renew_3registers_2}, {14'd0, mBoot3});
    checkOutput("register_num", register_num, mRegNum);
    checkOutput("dispatch_error", {14'd0, dispatch_error}, {14'd0, mError});
  endtask

  initial begin
    logic [REGS-1:0] tbl;
    rst = 1'b1; instr_valid = 1'b0; instr_sync = 1'b0; instr_multi = 1'b0;
    instr_rd = '0; instr_rs = '0; processing_register_table = '0;
    processor_idle_1 = 1'b0; processor_idle_2 = 1'b0; synchronized_processors = 1'b0;

    $display("[TB] reset with an acceptable instruction offered");
    repeat (3) applyStimulus(1, 1, 0, 0, 15'd5, 10'd0, '0, 1, 1, 1);

    $display("[TB] single-destination dispatch to processor 1");
    applyStimulus(0, 1, 0, 0, 15'd5, 10'd0, '0, 1, 1, 0);
    checkOutput("scenario1_regnum", {10'd0, register_num[4:0]}, 15'd5);
    applyStimulus(0, 1, 0, 0, 15'd8, 10'd0, '0, 1, 1, 0);
    applyStimulus(0, 0, 0, 0, 15'd0, 10'd0, '0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 15'd0, 10'd0, '0, 0, 1, 0);

    $display("[TB] three-destination dispatch to processor 2");
    applyStimulus(0, 1, 0, 1, {5'd7, 5'd6, 5'd3}, 10'd0, '0, 0, 1, 0);
    checkOutput("scenario2_regnum", register_num, {5'd7, 5'd6, 5'd3});
    applyStimulus(0, 1, 0, 1, {5'd7, 5'd6, 5'd3}, 10'd0, '0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 15'd0, 10'd0, '0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 15'd0, 10'd0, '0, 1, 1, 0);

    $display("[TB] source hazard held then released");
    tbl = 32'h0000_0010;
    repeat (3) applyStimulus(0, 1, 0, 0, 15'd9, {5'd4, 5'd2}, tbl, 1, 1, 0);
    applyStimulus(0, 1, 0, 0, 15'd9, {5'd4, 5'd2}, '0, 1, 1, 0);
    applyStimulus(0, 0, 0, 0, 15'd0, 10'd0, '0, 0, 1, 0);

    $display("[TB] destination zero never hazards");
    applyStimulus(0, 1, 0, 0, 15'd0, 10'd0, 32'h0000_0001, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 15'd0, 10'd0, '0, 0, 0, 0);

    $display("[TB] barrier waits for idle and coherent processors");
    applyStimulus(0, 1, 1, 0, 15'd0, 10'd0, '0, 1, 0, 1);
    repeat (5) applyStimulus(0, 1, 1, 0, 15'd0, 10'd0, '0, 1, 0, 1);
    applyStimulus(0, 1, 1, 0, 15'd0, 10'd0, '0, 1, 1, 1);
    applyStimulus(0, 0, 0, 0, 15'd0, 10'd0, '0, 1, 1, 1);

    $display("[TB] processor 1 never leaves idle after boot");
    applyStimulus(0, 1, 0, 0, 15'd12, 10'd0, '0, 1, 1, 0);
    repeat (TIMEOUT + 4) applyStimulus(0, 0, 0, 0, 15'd0, 10'd0, '0, 1, 1, 0);
    applyStimulus(1, 0, 0, 0, 15'd0, 10'd0, '0, 1, 1, 0);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 400; n++) begin
      applyStimulus($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0,
                    15'($urandom), 10'($urandom), $urandom & $urandom & $urandom,
                    $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0,
                    $urandom_range(0, 1) == 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
